// File: rtl/typec_cc_pkg.sv
// Shared types and constants for the Type-C CC attach detector.
// State encodings are exposed on the debug `state` output, so the values are fixed.
package typec_cc_pkg;

    typedef enum logic [2:0] {
        StUnattached    = 3'd0,
        StAttachWait    = 3'd1,
        StVbusWait      = 3'd2,
        StAttached      = 3'd3,
        StDetachWait    = 3'd4,
        StAccessory     = 3'd5,
        StErrorRecovery = 3'd6
    } cc_state_e;

    // CC code = {cc2, cc1}
    localparam logic [1:0] CC_NONE = 2'b00;
    localparam logic [1:0] CC_1    = 2'b01;
    localparam logic [1:0] CC_2    = 2'b10;
    localparam logic [1:0] CC_ACC  = 2'b11;

    // Plug orientation implied by a single-line CC code: 1 when CC2 carries the pull.
    function automatic logic cc_orientation(input logic [1:0] code);
        return (code == CC_2);
    endfunction

endpackage

// File: rtl/typec_cc_attach_detector_if.sv
// Connector-side signal bundle: sampled CC/VBUS levels in, attach status and events out.
// master drives the pins (connector / bench); slave is the detector.
interface typec_cc_attach_detector_if;

    logic       CC1;
    logic       CC2;
    logic       VBUS;
    logic       attached;
    logic       orientation;
    logic       accessory;
    logic       attach_evt;
    logic       detach_evt;
    logic [2:0] state;

    modport master (
        output CC1,
        output CC2,
        output VBUS,
        input  attached,
        input  orientation,
        input  accessory,
        input  attach_evt,
        input  detach_evt,
        input  state
    );

    modport slave (
        input  CC1,
        input  CC2,
        input  VBUS,
        output attached,
        output orientation,
        output accessory,
        output attach_evt,
        output detach_evt,
        output state
    );

endinterface

// File: rtl/cc_sync.sv
// Multi-bit two-flop synchronizer for independent, slowly changing level inputs.
// Each bit is synchronized on its own; no cross-bit coherency is implied.
module cc_sync #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
        end
    end

    assign data_o = sync_q;

endmodule

// File: rtl/typec_cc_attach_detector.sv
// Device-side Type-C attach detector: debounces CC, resolves orientation, waits for VBUS,
// and tracks detach. Debug accessories (both CC high) are reported but never "attached".
module typec_cc_attach_detector
    import typec_cc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    parameter int unsigned DETACH_CYCLES   = 4,
    parameter int unsigned VBUS_TIMEOUT    = 64,
    parameter int unsigned ERR_CYCLES      = 16,
    parameter int unsigned CNT_W           = 16
) (
    input logic                         clk,
    input logic                         reset,
    typec_cc_attach_detector_if.slave   bus
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DET_LAST  = CNT_W'(DETACH_CYCLES - 1);
    localparam logic [CNT_W-1:0] VBUS_LAST = CNT_W'(VBUS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(ERR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic [2:0] sync_in;
    logic [2:0] sync_out;
    logic       cc1_s;
    logic       cc2_s;
    logic       vbus_s;
    logic [1:0] code;

    assign sync_in = {bus.VBUS, bus.CC2, bus.CC1};

    cc_sync #(
        .WIDTH (3)
    ) u_cc_sync (
        .clk    (clk),
        .reset  (reset),
        .data_i (sync_in),
        .data_o (sync_out)
    );

    assign cc1_s  = sync_out[0];
    assign cc2_s  = sync_out[1];
    assign vbus_s = sync_out[2];
    assign code   = {cc2_s, cc1_s};

    // ------------------------------------------------------------------
    // State, counter and latched code
    // ------------------------------------------------------------------
    cc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_l_q, code_l_d;
    logic             relatch;

    logic attached_q, attached_d;
    logic orientation_q, orientation_d;
    logic accessory_q, accessory_d;
    logic attach_evt_q, attach_evt_d;
    logic detach_evt_q, detach_evt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StUnattached;
            cnt_q    <= '0;
            code_l_q <= CC_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_l_q <= code_l_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        code_l_d = code_l_q;
        relatch  = 1'b0;

        unique case (state_q)
            StUnattached: begin
                if (code != CC_NONE) begin
                    state_d  = StAttachWait;
                    code_l_d = code;
                end
            end

            StAttachWait: begin
                if (code == CC_NONE) begin
                    state_d = StUnattached;
                end else if (code != code_l_q) begin
                    // New nonzero code restarts the debounce window in place.
                    code_l_d = code;
                    relatch  = 1'b1;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = (code_l_q == CC_ACC) ? StAccessory : StVbusWait;
                end
            end

            StVbusWait: begin
                // CC changes outrank VBUS arrival.
                if (code == CC_NONE) begin
                    state_d = StUnattached;
                end else if (code != code_l_q) begin
                    state_d  = StAttachWait;
                    code_l_d = code;
                end else if (vbus_s) begin
                    state_d = StAttached;
                end else if (cnt_q == VBUS_LAST) begin
                    state_d = StErrorRecovery;
                end
            end

            StAttached: begin
                if (!vbus_s) begin
                    state_d = StErrorRecovery;
                end else if (code == CC_NONE) begin
                    state_d = StDetachWait;
                end
            end

            StDetachWait: begin
                if (code != CC_NONE) begin
                    state_d = StAttached;
                end else if (cnt_q == DET_LAST) begin
                    state_d = StUnattached;
                end
            end

            StAccessory: begin
                if (code != CC_ACC) begin
                    state_d = StUnattached;
                end
            end

            StErrorRecovery: begin
                if (cnt_q == ERR_LAST) begin
                    state_d = StUnattached;
                end
            end

            default: begin
                state_d = StUnattached;
            end
        endcase
    end

    // Shared dwell counter: restarts on any state change or relatch, saturates otherwise.
    always_comb begin
        if ((state_d != state_q) || relatch) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output logic (registered so flags and pulses move with state)
    // ------------------------------------------------------------------
    always_comb begin
        attached_d    = (state_d == StAttached) || (state_d == StDetachWait);
        accessory_d   = (state_d == StAccessory);
        attach_evt_d  = (state_q == StVbusWait) && (state_d == StAttached);
        detach_evt_d  = ((state_q == StDetachWait) && (state_d == StUnattached)) ||
                        ((state_q == StAttached) && (state_d == StErrorRecovery));
        orientation_d = orientation_q;
        if ((state_q == StAttachWait) && (state_d == StVbusWait)) begin
            orientation_d = cc_orientation(code_l_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            attached_q    <= 1'b0;
            orientation_q <= 1'b0;
            accessory_q   <= 1'b0;
            attach_evt_q  <= 1'b0;
            detach_evt_q  <= 1'b0;
        end else begin
            attached_q    <= attached_d;
            orientation_q <= orientation_d;
            accessory_q   <= accessory_d;
            attach_evt_q  <= attach_evt_d;
            detach_evt_q  <= detach_evt_d;
        end
    end

    assign bus.attached    = attached_q;
    assign bus.orientation = orientation_q;
    assign bus.accessory   = accessory_q;
    assign bus.attach_evt  = attach_evt_q;
    assign bus.detach_evt  = detach_evt_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_typec_cc_attach_detector.sv
// Directed and randomized checks of the CC attach detector against a timeline-based model
// that tracks phase entry times instead of a hardware counter.
module tb_typec_cc_attach_detector;

    localparam int DEB = 10;
    localparam int DET = 4;
    localparam int VTO = 64;
    localparam int ERR = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    typec_cc_attach_detector_if bus ();

    typec_cc_attach_detector #(
        .DEBOUNCE_CYCLES (DEB),
        .DETACH_CYCLES   (DET),
        .VBUS_TIMEOUT    (VTO),
        .ERR_CYCLES      (ERR),
        .CNT_W           (16)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_pass;
    int n_chk;

    // Model: phase 0..6 as numbered by the debug output, plus the edge at which it was entered.
    int       m_phase;
    int       m_enter;
    int       m_edge;
    int       m_code_l;
    int       m_orient;
    int       m_att_evt;
    int       m_det_evt;
    logic [2:0] m_pipe1;
    logic [2:0] m_pipe2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_enter   = m_edge;
        m_code_l  = 0;
        m_orient  = 0;
        m_att_evt = 0;
        m_det_evt = 0;
        m_pipe1   = 3'b000;
        m_pipe2   = 3'b000;
    endtask

    // One clock edge of the reference: CC/VBUS as seen two edges ago drive the rules.
    task automatic model_edge();
        int  c;
        int  nxt;
        int  held;
        logic v;
        c = int'(m_pipe2[1:0]);
        v = m_pipe2[2];
        m_edge++;
        held = m_edge - m_enter;
        nxt = m_phase;
        m_att_evt = 0;
        m_det_evt = 0;
        case (m_phase)
            0: if (c != 0) begin nxt = 1; m_code_l = c; end
            1: begin
                if (c == 0) nxt = 0;
                else if (c != m_code_l) begin m_code_l = c; m_enter = m_edge; end
                else if (held == DEB) nxt = (c == 3) ? 5 : 2;
            end
            2: begin
                if (c == 0) nxt = 0;
                else if (c != m_code_l) begin nxt = 1; m_code_l = c; end
                else if (v) begin nxt = 3; m_att_evt = 1; end
                else if (held == VTO) nxt = 6;
            end
            3: begin
                if (!v) begin nxt = 6; m_det_evt = 1; end
                else if (c == 0) nxt = 4;
            end
            4: begin
                if (c != 0) nxt = 3;
                else if (held == DET) begin nxt = 0; m_det_evt = 1; end
            end
            5: if (c != 3) nxt = 0;
            6: if (held == ERR) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt == 2 && m_phase == 1) m_orient = (m_code_l == 2) ? 1 : 0;
        if (nxt != m_phase) m_enter = m_edge;
        m_phase = nxt;
        m_pipe2 = m_pipe1;
        m_pipe1 = {bus.VBUS, bus.CC2, bus.CC1};
    endtask

    task automatic check_all();
        chk("state",       {29'd0, bus.state},   m_phase);
        chk("attached",    {31'd0, bus.attached}, (m_phase == 3 || m_phase == 4) ? 1 : 0);
        chk("accessory",   {31'd0, bus.accessory}, (m_phase == 5) ? 1 : 0);
        chk("orientation", {31'd0, bus.orientation}, m_orient);
        chk("attach_evt",  {31'd0, bus.attach_evt}, m_att_evt);
        chk("detach_evt",  {31'd0, bus.detach_evt}, m_det_evt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    int evts;
    int lat;
    int r;

    initial begin
        n_pass = 0;
        n_chk  = 0;
        m_edge = 0;
        bus.CC1  = 1'b0;
        bus.CC2  = 1'b0;
        bus.VBUS = 1'b0;
        model_reset();

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state",    {29'd0, bus.state}, 0);
        chk("reset_attached", {31'd0, bus.attached}, 0);
        chk("reset_accessory", {31'd0, bus.accessory}, 0);
        chk("reset_orient",   {31'd0, bus.orientation}, 0);
        chk("reset_evts",     {30'd0, bus.attach_evt, bus.detach_evt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: no events
        evts = 0;
        repeat (100) begin
            tick();
            evts += int'(bus.attach_evt) + int'(bus.detach_evt);
        end
        chk("idle_events", evts, 0);

        // CC1 attach with VBUS present
        bus.VBUS = 1'b1;
        repeat (3) tick();
        bus.CC1 = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.attach_evt === 1'b1) begin lat = i - 1; break; end
        end
        chk("attach_latency_cc1", lat, 13);
        chk("orient_cc1",   {31'd0, bus.orientation}, 0);
        chk("attached_cc1", {31'd0, bus.attached}, 1);
        repeat (3) tick();

        // Detach CC1
        bus.CC1 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.detach_evt === 1'b1) begin lat = i - 1; break; end
        end
        chk("detach_latency_cc1", lat, 6);
        repeat (4) tick();

        // CC2 attach
        bus.CC2 = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.attach_evt === 1'b1) begin lat = i - 1; break; end
        end
        chk("attach_latency_cc2", lat, 13);
        chk("orient_cc2", {31'd0, bus.orientation}, 1);

        // Short glitch must be absorbed
        bus.CC2 = 1'b0;
        repeat (3) tick();
        bus.CC2 = 1'b1;
        evts = 0;
        repeat (10) begin
            tick();
            evts += int'(bus.attach_evt) + int'(bus.detach_evt);
        end
        chk("glitch_events",   evts, 0);
        chk("glitch_attached", {31'd0, bus.attached}, 1);

        // Real detach
        bus.CC2 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.detach_evt === 1'b1) begin lat = i - 1; break; end
        end
        chk("detach_latency_cc2", lat, 6);
        chk("detach_state", {29'd0, bus.state}, 0);

        // Too-short CC1 assertion
        bus.CC1 = 1'b1;
        repeat (5) tick();
        bus.CC1 = 1'b0;
        evts = 0;
        repeat (20) begin
            tick();
            evts += int'(bus.attach_evt) + int'(bus.detach_evt) + int'(bus.attached);
        end
        chk("short_cc_events", evts, 0);
        chk("short_cc_state", {29'd0, bus.state}, 0);

        // Debug accessory
        bus.CC1 = 1'b1;
        bus.CC2 = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.accessory === 1'b1) begin lat = i - 1; break; end
        end
        chk("accessory_latency", lat, 12);
        chk("accessory_not_attached", {31'd0, bus.attached}, 0);
        bus.CC2 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.accessory === 1'b0) begin lat = i - 1; break; end
        end
        chk("accessory_release", lat, 2);
        chk("accessory_release_state", {29'd0, bus.state}, 0);
        bus.CC1 = 1'b0;
        repeat (20) tick();

        // VBUS never arrives: timeout, recovery, then re-attach
        bus.VBUS = 1'b0;
        repeat (5) tick();
        bus.CC1 = 1'b1;
        lat = -1;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (bus.state === 3'd6) begin lat = i - 1; break; end
        end
        chk("vbus_timeout_edge", lat, 2 + DEB + VTO);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.state === 3'd0) begin lat = i; break; end
        end
        chk("err_recovery_len", lat, ERR);
        bus.VBUS = 1'b1;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus.attach_evt === 1'b1) begin lat = i; break; end
        end
        chk("reattach_seen", (lat > 0) ? 1 : 0, 1);

        // VBUS loss while attached
        bus.VBUS = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.detach_evt === 1'b1) begin lat = i - 1; break; end
        end
        chk("vbus_loss_latency", lat, 2);
        chk("vbus_loss_state", {29'd0, bus.state}, 6);
        repeat (20) tick();

        // Reset while attached
        bus.VBUS = 1'b1;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus.attached === 1'b1) begin lat = i; break; end
        end
        chk("attached_before_reset", (lat > 0) ? 1 : 0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_mid_attached",   {31'd0, bus.attached}, 0);
        chk("reset_mid_detach_evt", {31'd0, bus.detach_evt}, 0);
        chk("reset_mid_state",      {29'd0, bus.state}, 0);
        model_reset();
        bus.CC1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();

        // Randomized segments of held CC/VBUS patterns
        for (int seg = 0; seg < 80; seg++) begin
            r = int'($urandom_range(0, 9));
            bus.CC1  = (r >= 3 && r <= 5) || (r == 9);
            bus.CC2  = (r >= 6);
            bus.VBUS = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(1, 24)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/typec_cc_attach_detector.md
# typec_cc_attach_detector

Device-side counterpart of the host model's CC/VBUS drive: samples the host's CC1, CC2 and VBUS lines, debounces attachment, resolves plug orientation, and tracks detach. Sits between the Type-C connector pins and the authentication controller, which starts authentication on `attach_evt` and aborts on `detach_evt`. Detects debug-accessory attachment (both CC lines high) and leaves it unattached for authentication purposes.

## Interface
- `DEBOUNCE_CYCLES`, 10: stable cycles required in ATTACH_WAIT (tCCDebounce).
- `DETACH_CYCLES`, 4: cycles of CC=none required to confirm detach.
- `VBUS_TIMEOUT`, 64: maximum cycles in VBUS_WAIT before error recovery.
- `ERR_CYCLES`, 16: cycles held in ERROR_RECOVERY.
- `CNT_W`, 16: shared counter width; every cycle parameter must be ≤ 2^CNT_W−1.
- `clk` in 1: single clock, 100 MHz.
- `reset` in 1: asynchronous, active-low; all flops clear on assertion.
- `CC1` in 1: digitized CC1 level, asynchronous to `clk`.
- `CC2` in 1: digitized CC2 level, asynchronous.
- `VBUS` in 1: VBUS-present level, asynchronous.
- `attached` out 1: high in ATTACHED and DETACH_WAIT.
- `orientation` out 1: 0 = CC1 active, 1 = CC2 active; updated only on entry to VBUS_WAIT.
- `accessory` out 1: high in ACCESSORY.
- `attach_evt` out 1: one-cycle pulse on entry to ATTACHED from VBUS_WAIT.
- `detach_evt` out 1: one-cycle pulse on DETACH_WAIT→UNATTACHED or ATTACHED→ERROR_RECOVERY.
- `state` out 3: current state encoding, for debug.

## Operation
- 2-flop synchronizer on CC1, CC2 and VBUS → `cc1_s`, `cc2_s`, `vbus_s`; `code = {cc2_s, cc1_s}`: 00 none, 01 CC1, 10 CC2, 11 accessory.
- Single counter `cnt`, cleared on every state change; saturates, never wraps.
- UNATTACHED (0): code≠00 → ATTACH_WAIT, latch `code` into `code_l`.
- ATTACH_WAIT (1): code==00 → UNATTACHED; code≠code_l and ≠00 → stay, relatch, cnt=0; code==code_l → cnt++; at cnt==DEBOUNCE_CYCLES−1 with stable code: code_l==11 → ACCESSORY, else → VBUS_WAIT with orientation=code_l[1].
- VBUS_WAIT (2): code==00 → UNATTACHED; code≠code_l → ATTACH_WAIT (relatch); vbus_s → ATTACHED; cnt==VBUS_TIMEOUT−1 → ERROR_RECOVERY. CC checks take priority over vbus_s.
- ATTACHED (3): vbus_s low → ERROR_RECOVERY; else code==00 → DETACH_WAIT. Nonzero code changes, including orientation swaps, are ignored.
- DETACH_WAIT (4): code≠00 → ATTACHED (no events); cnt==DETACH_CYCLES−1 → UNATTACHED. VBUS is ignored here.
- ACCESSORY (5): code≠11 → UNATTACHED immediately.
- ERROR_RECOVERY (6): ignores inputs; cnt==ERR_CYCLES−1 → UNATTACHED.
- Reset values: state UNATTACHED, all outputs 0, sync flops 0, cnt 0, code_l 00. Reset assertion mid-attach drops `attached` asynchronously without a `detach_evt`.

## Timing
- All outputs are registered, and state, flags and pulses change on the same edge.
- Let E0 be the first edge sampling CC high. `cc*_s` updates at E1; ATTACH_WAIT begins at E2. VBUS_WAIT begins at E2+DEBOUNCE_CYCLES. With VBUS already high, ATTACHED and `attach_evt` occur at E3+DEBOUNCE_CYCLES: 13 cycles with defaults.
- Detach: CC low sampled at E0 → DETACH_WAIT at E2 → UNATTACHED and `detach_evt` at E2+DETACH_CYCLES.
- Glitches shorter than DETACH_CYCLES while attached produce no events.

## Structure
- Package `typec_cc_pkg`: 3-bit state encodings (values above), CC code constants (CC_NONE, CC_1, CC_2, CC_ACC).
- Sub-module `cc_sync`: 3-bit, 2-flop synchronizer with async active-low reset to 0.
- Top: FSM, counter, and output registers; about 200 lines.

## Test plan
- Reset low for 2 cycles, then release with CC1=CC2=0 → state 0 and all outputs 0; no event for 100 cycles.
- VBUS=1, then CC1 raised and held → `attach_evt` pulse exactly 13 cycles after the first sampling edge, `orientation`=0, `attached`=1.
- CC2 raised with VBUS=1 → `orientation`=1. Then CC2 dropped for 3 cycles → no `detach_evt`. Then CC2 dropped and held → `detach_evt` 6 cycles after the sampling edge, state 0.
- CC1 high for 5 cycles, then 0 → returns to UNATTACHED with no events. CC1=CC2=1 held → `accessory`=1 after 12 cycles; CC2 released → `accessory`=0, state 0.
- CC1 held with VBUS=0 → VBUS_WAIT for 64 cycles → ERROR_RECOVERY for 16 cycles → UNATTACHED, then re-attach attempt.
- While ATTACHED, drop VBUS → `detach_evt` at the ERROR_RECOVERY entry edge. Separately, assert reset while ATTACHED → `attached`=0 immediately with no pulse.
